noc_link_tx: RTL and testbench
==============================

// Module: noc_link_tx
// PURPOSE
//  Output-port transmitter for one mesh link. It sends flits from a router output port onto the
//  inter-router flit link and tracks downstream input-buffer space with per-VC credit counters.
//  Credits return from the neighbour's receiver on the reverse path. One instance per output port.
//  The block arbitrates between ready VCs round-robin and registers the chosen flit onto the link.
// PARAMETERS
//  NUM_VC     4   virtual channels per link
//  BUF_DEPTH  4   flit slots per VC in the downstream input buffer; also the reset credit count
//  CRED_W     $clog2(BUF_DEPTH+1)   credit counter width, derived, not overridable
// PORTS
//  clk          in   1                   single clock, all state on rising edge
//  reset        in   1                   asynchronous, active-high
//  in_valid     in   NUM_VC              switch offers a flit on VC v
//  in_flit      in   NUM_VC x NOC_LINK_W flit payload per VC
//  in_ready     out  NUM_VC              one-hot grant; the flit on VC v is consumed this cycle
//  link_valid   out  1                   flit present on the link this cycle
//  link_vc      out  VC_ID_W             VC of the flit on the link
//  link_flit    out  NOC_LINK_W          flit data on the link
//  cred_valid   in   1                   downstream freed one slot
//  cred_vc      in   VC_ID_W             VC of the returned credit
//  credits      out  NUM_VC x CRED_W     current counters, for debug and idle detection
//  cred_err     out  1                   sticky error: credit overflow
// BEHAVIOUR
//  Reset (async assert): every credits[v]=BUF_DEPTH, rr pointer=0, link_valid=0, link_vc=0,
//   link_flit=0, cred_err=0. in_ready is combinational and is 0 while reset is high.
//  Eligible VC v: in_valid[v] && credits[v]!=0. The arbiter grants at most one eligible VC per
//   cycle. Search order starts at the VC after the last granted VC. in_ready=grant, same cycle.
//  A grant on VC g at edge t drives link_valid=1, link_vc=g, link_flit=in_flit[g] from t+1 for
//   one cycle. Latency is 1 cycle. With no grant, link_valid=0, and link_flit/link_vc hold.
//  Credit update per VC each cycle: dec = grant[v]; inc = cred_valid && cred_vc==v.
//   Both high: no change. dec only: -1. inc only: +1.
//  Returned credit with credits[v]==BUF_DEPTH and no dec: counter saturates at BUF_DEPTH and
//   cred_err sets. cred_err clears only on reset.
//  Decrement at 0 cannot occur because the eligibility check prevents it.
//  A credit returned in the same cycle a VC sits at 0 is not usable until the next cycle.
//   The eligibility check uses registered counters only, with no combinational cred->ready path.
//  The rr pointer advances to g only on a grant. With no grant it holds.
//  cred_vc >= NUM_VC while cred_valid is high: the credit is ignored and cred_err sets.
//  Reset mid-transfer drops the in-flight link flit. The downstream side is reset together with
//   this block, so the credits realign to BUF_DEPTH.
// STRUCTURE
//  router_pkg: add NUM_VC, VC_ID_W=$clog2(NUM_VC), BUF_DEPTH, and typedef flit_t =
//   logic [NOC_LINK_W-1:0]. NOC_LINK_W stays where it is.
//  Sub-module rr_arbiter #(N) holds the request vector, one-hot grant and rotating pointer.
//   It is reused later by the switch allocator.
//  Credit counters are a generate loop in this module. The data_web equivalent for credits is
//   a separate wiring block.
// TESTING
//  1 Reset, no traffic -> credits all 4, link_valid=0, cred_err=0, in_ready=0.
//  2 in_valid=4'b0001 held 6 cycles, no credits returned -> exactly 4 flits on link_vc=0 on
//    cycles 1..4; credits[0]=0; in_ready[0]=0 afterwards; link_valid=0.
//  3 in_valid=4'b1111 held, credits returned each cycle for the link_vc -> link_vc sequence
//    0,1,2,3,0,1,... with one flit per cycle and no VC starved.
//  4 credits[2]=0 with in_valid[2]=1, then cred_valid with cred_vc=2 at edge t -> credits[2]=1
//    after t, in_ready[2]=1 in cycle t+1, flit on link at t+2.
//  5 Grant and credit return on the same VC in one cycle -> counter unchanged. Extra credit on a
//    full VC -> stays at 4 and cred_err=1. cred_vc=5 with NUM_VC=4 -> cred_err=1.
//  6 Assert reset asynchronously mid-burst, between edges -> link_valid drops immediately,
//    credits go to 4, and traffic resumes from VC0 after release.

Source files
------------

// File: rtl/router_pkg.sv
// Shared router parameters and types for the mesh NoC.
package router_pkg;
  localparam int NOC_LINK_W = 32;
  localparam int NUM_VC     = 4;
  localparam int VC_ID_W    = $clog2(NUM_VC);
  localparam int BUF_DEPTH  = 4;

  typedef logic [NOC_LINK_W-1:0] flit_t;
endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant over N requests with a rotating start pointer.
module rr_arbiter #(
  parameter int N = 4,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [N-1:0]  req,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_id
);
  // ptr is the first index searched, i.e. one past the last grant
  logic [IW-1:0] ptr;
  logic          found;
  int            idx;

  always_comb begin
    grant    = '0;
    grant_id = '0;
    found    = 1'b0;
    idx      = 0;
    for (int i = 0; i < N; i++) begin
      idx = (int'(ptr) + i) % N;
      if (!found && req[idx]) begin
        found       = 1'b1;
        grant[idx]  = 1'b1;
        grant_id    = IW'(idx);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      ptr <= '0;
    else if (found)
      ptr <= (int'(grant_id) == N-1) ? '0 : grant_id + IW'(1);
  end
endmodule

// File: rtl/noc_link_tx.sv
// Mesh link transmitter: round-robin VC selection gated by per-VC downstream credits.
module noc_link_tx
  import router_pkg::*;
#(
  parameter int NVC   = NUM_VC,
  parameter int DEPTH = BUF_DEPTH,
  localparam int VW     = (NVC > 1) ? $clog2(NVC) : 1,
  localparam int CRED_W = $clog2(DEPTH + 1)
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [NVC-1:0]                   in_valid,
  input  logic [NVC-1:0][NOC_LINK_W-1:0]   in_flit,
  output logic [NVC-1:0]                   in_ready,
  output logic                             link_valid,
  output logic [VW-1:0]                    link_vc,
  output logic [NOC_LINK_W-1:0]            link_flit,
  input  logic                             cred_valid,
  input  logic [VW-1:0]                    cred_vc,
  output logic [NVC-1:0][CRED_W-1:0]       credits,
  output logic                             cred_err
);
  logic [NVC-1:0] avail, req, grant, ovf;
  logic [VW-1:0]  gnt_id;
  logic           bad_vc;

  // Only registered counters feed eligibility; a same-cycle credit never unblocks a VC.
  assign req      = in_valid & avail & {NVC{~reset}};
  assign in_ready = grant;
  assign bad_vc   = cred_valid && (int'(cred_vc) >= NVC);

  rr_arbiter #(.N(NVC)) u_arb (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .grant    (grant),
    .grant_id (gnt_id)
  );

  for (genvar v = 0; v < NVC; v++) begin : g_cred
    logic [CRED_W-1:0] cnt_q;
    logic              inc, dec;

    assign inc      = cred_valid && (cred_vc == VW'(v));
    assign dec      = grant[v];
    assign ovf[v]   = inc && !dec && (cnt_q == CRED_W'(DEPTH));
    assign avail[v] = (cnt_q != '0);
    assign credits[v] = cnt_q;

    always_ff @(posedge clk or posedge reset) begin
      if (reset)
        cnt_q <= CRED_W'(DEPTH);
      else if (dec && !inc)
        cnt_q <= cnt_q - CRED_W'(1);
      else if (inc && !dec && !ovf[v])
        cnt_q <= cnt_q + CRED_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      link_valid <= 1'b0;
      link_vc    <= '0;
      link_flit  <= '0;
      cred_err   <= 1'b0;
    end else begin
      link_valid <= |grant;
      if (|grant) begin
        link_vc   <= gnt_id;
        link_flit <= in_flit[gnt_id];
      end
      if ((|ovf) || bad_vc)
        cred_err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_noc_link_tx.sv
// Directed bench for noc_link_tx: vector table plus multi-cycle corner sequences.
module tb_noc_link_tx;
  import router_pkg::*;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [3:0]       in_valid = '0;
  logic [3:0][31:0] in_flit = '0;
  logic [3:0]       in_ready;
  logic             link_valid;
  logic [1:0]       link_vc;
  logic [31:0]      link_flit;
  logic             cred_valid = 1'b0;
  logic [1:0]       cred_vc = '0;
  logic [3:0][2:0]  credits;
  logic             cred_err;

  // three-VC instance so an out-of-range cred_vc is representable
  logic [2:0]       in_valid3 = '0;
  logic [2:0][31:0] in_flit3 = '0;
  logic [2:0]       in_ready3;
  logic             link_valid3;
  logic [1:0]       link_vc3;
  logic [31:0]      link_flit3;
  logic             cred_valid3 = 1'b0;
  logic [1:0]       cred_vc3 = '0;
  logic [2:0][2:0]  credits3;
  logic             cred_err3;

  int total = 0;
  int pass  = 0;
  flit_t last_flit = '0;

  always #5 clk = ~clk;

  noc_link_tx u_dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_flit(in_flit), .in_ready(in_ready),
    .link_valid(link_valid), .link_vc(link_vc), .link_flit(link_flit),
    .cred_valid(cred_valid), .cred_vc(cred_vc), .credits(credits), .cred_err(cred_err)
  );

  noc_link_tx #(.NVC(3), .DEPTH(4)) u_dut3 (
    .clk(clk), .reset(reset), .in_valid(in_valid3), .in_flit(in_flit3), .in_ready(in_ready3),
    .link_valid(link_valid3), .link_vc(link_vc3), .link_flit(link_flit3),
    .cred_valid(cred_valid3), .cred_vc(cred_vc3), .credits(credits3), .cred_err(cred_err3)
  );

  typedef struct {
    logic        rst;
    logic [3:0]  v;
    logic        cv;
    logic [1:0]  cvc;
    logic [3:0]  rdy;
    logic        lv;
    logic [1:0]  lvc;
    logic [11:0] cr;
    logic        err;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [11:0] cr(int c3, int c2, int c1, int c0);
    return {3'(c3), 3'(c2), 3'(c1), 3'(c0)};
  endfunction

  function automatic flit_t fl(int v, int i);
    return {8'(v), 8'hC0, 16'(i)};
  endfunction

  task automatic add(input logic rst, input logic [3:0] v, input logic cv, input logic [1:0] cvc,
                     input logic [3:0] rdy, input logic lv, input logic [1:0] lvc,
                     input logic [11:0] c, input logic err);
    vec_t r;
    r.rst = rst; r.v = v; r.cv = cv; r.cvc = cvc; r.rdy = rdy;
    r.lv = lv; r.lvc = lvc; r.cr = c; r.err = err;
    tbl.push_back(r);
  endtask

  task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
    total++;
    if (a === e) pass++;
    else $display("FAIL %s: got %0h want %0h", nm, a, e);
  endtask

  task automatic set_flits(input int i);
    for (int v = 0; v < 4; v++) in_flit[v] = fl(v, i);
  endtask

  // reset asserted between edges, with traffic offered to prove in_ready is gated
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; in_valid = 4'hF; cred_valid = 1'b0;
    #1;
    chk("rst_ready", 64'(in_ready), 64'h0);
    chk("rst_lv", 64'(link_valid), 64'h0);
    chk("rst_credits", 64'(credits), 64'(cr(4,4,4,4)));
    chk("rst_err", 64'(cred_err), 64'h0);
    @(negedge clk);
    reset = 1'b0; in_valid = '0;
    last_flit = '0;
  endtask

  initial begin
    // reset state / single-VC drain / credit unblock on VC0
    add(1,4'b0001,0,0,4'b0001,1,0,cr(4,4,4,3),0);
    add(0,4'b0001,0,0,4'b0001,1,0,cr(4,4,4,2),0);
    add(0,4'b0001,0,0,4'b0001,1,0,cr(4,4,4,1),0);
    add(0,4'b0001,0,0,4'b0001,1,0,cr(4,4,4,0),0);
    add(0,4'b0001,0,0,4'b0000,0,0,cr(4,4,4,0),0);
    add(0,4'b0001,0,0,4'b0000,0,0,cr(4,4,4,0),0);
    add(0,4'b0001,1,0,4'b0000,0,0,cr(4,4,4,1),0);
    add(0,4'b0001,0,0,4'b0001,1,0,cr(4,4,4,0),0);
    // all VCs offered, credit returned for the flit on the link
    add(1,4'b1111,0,0,4'b0001,1,0,cr(4,4,4,3),0);
    add(0,4'b1111,1,0,4'b0010,1,1,cr(4,4,3,4),0);
    add(0,4'b1111,1,1,4'b0100,1,2,cr(4,3,4,4),0);
    add(0,4'b1111,1,2,4'b1000,1,3,cr(3,4,4,4),0);
    add(0,4'b1111,1,3,4'b0001,1,0,cr(4,4,4,3),0);
    add(0,4'b1111,1,0,4'b0010,1,1,cr(4,4,3,4),0);
    // same-cycle grant and credit, then overflow on a full VC
    add(1,4'b0001,0,0,4'b0001,1,0,cr(4,4,4,3),0);
    add(0,4'b0001,1,0,4'b0001,1,0,cr(4,4,4,3),0);
    add(0,4'b0000,1,1,4'b0000,0,0,cr(4,4,4,3),1);
    add(0,4'b0000,0,0,4'b0000,0,0,cr(4,4,4,3),1);

    #2;
    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].rst) do_reset();
      in_valid = tbl[i].v; cred_valid = tbl[i].cv; cred_vc = tbl[i].cvc;
      set_flits(i);
      #1;
      chk($sformatf("row%0d_ready", i), 64'(in_ready), 64'(tbl[i].rdy));
      @(posedge clk); #1;
      if (tbl[i].lv) last_flit = fl(int'(tbl[i].lvc), i);
      chk($sformatf("row%0d_lv", i), 64'(link_valid), 64'(tbl[i].lv));
      chk($sformatf("row%0d_lvc", i), 64'(link_vc), 64'(tbl[i].lvc));
      chk($sformatf("row%0d_flit", i), 64'(link_flit), 64'(last_flit));
      chk($sformatf("row%0d_credits", i), 64'(credits), 64'(tbl[i].cr));
      chk($sformatf("row%0d_err", i), 64'(cred_err), 64'(tbl[i].err));
    end
    cred_valid = 1'b0;

    // VC2 drained to zero; a credit at edge t unblocks it in cycle t+1
    do_reset();
    in_valid = 4'b0100; set_flits(50);
    repeat (4) begin @(posedge clk); #1; end
    chk("vc2_empty", 64'(credits[2]), 64'h0);
    cred_valid = 1'b1; cred_vc = 2'd2;
    #1;
    chk("vc2_ready_same_cycle", 64'(in_ready), 64'h0);
    @(posedge clk); #1;
    cred_valid = 1'b0;
    chk("vc2_credit_back", 64'(credits[2]), 64'h1);
    chk("vc2_lv_idle", 64'(link_valid), 64'h0);
    #1;
    chk("vc2_ready_next", 64'(in_ready), 64'h4);
    @(posedge clk); #1;
    chk("vc2_lv", 64'(link_valid), 64'h1);
    chk("vc2_lvc", 64'(link_vc), 64'h2);
    chk("vc2_flit", 64'(link_flit), 64'(fl(2, 50)));
    chk("vc2_credit_used", 64'(credits[2]), 64'h0);
    in_valid = '0;

    // out-of-range credit VC on the three-VC instance
    chk("oor_err_before", 64'(cred_err3), 64'h0);
    cred_valid3 = 1'b1; cred_vc3 = 2'd3;
    @(posedge clk); #1;
    cred_valid3 = 1'b0;
    chk("oor_err", 64'(cred_err3), 64'h1);
    chk("oor_credits", 64'(credits3), 64'({3'd4, 3'd4, 3'd4}));

    // asynchronous reset mid-burst, then traffic restarts from VC0
    do_reset();
    in_valid = 4'hF; set_flits(100);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("burst_lv", 64'(link_valid), 64'h1);
    chk("burst_lvc", 64'(link_vc), 64'h1);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_lv", 64'(link_valid), 64'h0);
    chk("arst_lvc", 64'(link_vc), 64'h0);
    chk("arst_credits", 64'(credits), 64'(cr(4,4,4,4)));
    chk("arst_ready", 64'(in_ready), 64'h0);
    chk("arst_err3", 64'(cred_err3), 64'h0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("resume_ready", 64'(in_ready), 64'h1);
    @(posedge clk); #1;
    chk("resume_lv", 64'(link_valid), 64'h1);
    chk("resume_lvc", 64'(link_vc), 64'h0);
    chk("resume_flit", 64'(link_flit), 64'(fl(0, 100)));
    chk("resume_credits", 64'(credits), 64'(cr(4,4,4,3)));
    in_valid = '0;

    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
